// File: rtl/led_scan_pkg.sv
// Shared scan-state encoding and default geometry for the LED row scanner.
package led_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    SHOW
  } scan_state_e;

  localparam int DEF_COLS     = 32;
  localparam int DEF_ROW_BITS = 1;
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_SHOW_CYC = 256;

endpackage

// File: rtl/led_clk_div.sv
// Half-period tick generator for the panel shift clock; counts 0..CLK_DIV-1 while enabled.
module led_clk_div #(
  parameter int CLK_DIV = 4,
  localparam int CW = $clog2(CLK_DIV + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          restart_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tick_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && (cnt_q == CW'(CLK_DIV - 1));
    cnt_d  = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/led_row_scanner.sv
// LED-matrix row scanner: shift COLS pixels, latch, show SHOW_CYC cycles, next row.
// Define LED_SCAN_BLANK_EN to keep the panel dark everywhere except the SHOW phase.
module led_row_scanner
  import led_scan_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int SHOW_CYC = DEF_SHOW_CYC
) (
  input  logic                               clkin,
  input  logic                               rstnin,
  input  logic                               enin,
  output logic [ROW_BITS+$clog2(COLS)-1:0]   pix_addr,
  input  logic                               pix_data,
  output logic                               R1out,
  output logic [ROW_BITS-1:0]                Aout,
  output logic                               sclk_out,
  output logic                               latout,
  output logic                               oe_nout,
  output logic                               frame_done
);

  localparam int COL_W    = $clog2(COLS);
  localparam int DIV_W    = $clog2(CLK_DIV + 1);
  localparam int SHOW_W   = $clog2(SHOW_CYC + 1);
  localparam int AW       = ROW_BITS + COL_W;
  localparam int LOAD_CNT = (CLK_DIV == 1) ? 0 : 1;

  localparam logic [COL_W-1:0]    LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW  = {ROW_BITS{1'b1}};
  localparam logic [SHOW_W-1:0]   LAST_SHOW = SHOW_W'(SHOW_CYC - 1);

  scan_state_e         state_q, state_d;
  logic                half_q, half_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [SHOW_W-1:0]   show_q, show_d;
  logic [AW-1:0]       pix_addr_q, pix_addr_d;
  logic                r1_q, r1_d;
  logic [ROW_BITS-1:0] a_q, a_d;
  logic                sclk_q, sclk_d;
  logic                lat_q, lat_d;
  logic                oe_n_q, oe_n_d;
  logic                fd_q, fd_d;

  logic [DIV_W-1:0]    div_cnt;
  logic                div_tick;
  logic                div_en;

  assign div_en = (state_q == SHIFT) || (state_q == LATCH);

  led_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk_i     (clkin),
    .rst_n_i   (rstnin),
    .restart_i (!div_en),
    .en_i      (div_en),
    .cnt_o     (div_cnt),
    .tick_o    (div_tick)
  );

  // With CLK_DIV=1 the low half is a single cycle, so the address is issued one cycle early.
  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    col_d      = col_q;
    row_d      = row_q;
    show_d     = show_q;
    pix_addr_d = pix_addr_q;
    r1_d       = r1_q;
    a_d        = a_q;
    fd_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (enin) begin
          state_d    = SHIFT;
          half_d     = 1'b0;
          col_d      = '0;
          row_d      = '0;
          pix_addr_d = '0;
        end
      end

      SHIFT: begin
        if (!half_q && (div_cnt == DIV_W'(LOAD_CNT))) begin
          r1_d = pix_data;
        end
        if (div_tick) begin
          if (!half_q) begin
            half_d = 1'b1;
            if ((CLK_DIV == 1) && (col_q != LAST_COL)) begin
              pix_addr_d = {row_q, col_q + COL_W'(1)};
            end
          end else if (col_q == LAST_COL) begin
            state_d = LATCH;
            half_d  = 1'b0;
            col_d   = '0;
            a_d     = row_q;
          end else begin
            half_d = 1'b0;
            col_d  = col_q + COL_W'(1);
            if (CLK_DIV != 1) begin
              pix_addr_d = {row_q, col_q + COL_W'(1)};
            end
          end
        end
      end

      LATCH: begin
        if (div_tick) begin
          state_d = SHOW;
          show_d  = '0;
          if (CLK_DIV == 1) begin
            pix_addr_d = {row_q + ROW_BITS'(1), COL_W'(0)};
          end
        end
      end

      SHOW: begin
        show_d = show_q + SHOW_W'(1);
        if (show_q == LAST_SHOW) begin
          show_d  = '0;
          row_d   = row_q + ROW_BITS'(1);
          state_d = SHIFT;
          if (CLK_DIV != 1) begin
            pix_addr_d = {row_q + ROW_BITS'(1), COL_W'(0)};
          end
          if (row_q == LAST_ROW) begin
            fd_d = 1'b1;
            if (!enin) begin
              state_d = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    sclk_d = (state_d == SHIFT) && half_d;
    lat_d  = (state_d == LATCH);
`ifdef LED_SCAN_BLANK_EN
    oe_n_d = (state_d != SHOW);
`else
    oe_n_d = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clkin or negedge rstnin) begin
    if (!rstnin) begin
      state_q    <= IDLE;
      half_q     <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      show_q     <= '0;
      pix_addr_q <= '0;
      r1_q       <= 1'b0;
      a_q        <= '0;
      sclk_q     <= 1'b0;
      lat_q      <= 1'b0;
      oe_n_q     <= 1'b1;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      col_q      <= col_d;
      row_q      <= row_d;
      show_q     <= show_d;
      pix_addr_q <= pix_addr_d;
      r1_q       <= r1_d;
      a_q        <= a_d;
      sclk_q     <= sclk_d;
      lat_q      <= lat_d;
      oe_n_q     <= oe_n_d;
      fd_q       <= fd_d;
    end
  end

  assign pix_addr   = pix_addr_q;
  assign R1out      = r1_q;
  assign Aout       = a_q;
  assign sclk_out   = sclk_q;
  assign latout     = lat_q;
  assign oe_nout    = oe_n_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_led_row_scanner.sv
// Directed bench for led_row_scanner with a 4x2 pixel store and a registered-read model.
module tb_led_row_scanner;

  localparam int COLS     = 4;
  localparam int ROW_BITS = 1;
  localparam int CLK_DIV  = 2;
  localparam int SHOW_CYC = 8;
  localparam int AW       = ROW_BITS + $clog2(COLS);

`ifdef LED_SCAN_BLANK_EN
  localparam logic OE_SCAN = 1'b1;
`else
  localparam logic OE_SCAN = 1'b0;
`endif

  logic                clkin = 1'b0;
  logic                rstnin;
  logic                enin;
  logic [AW-1:0]       pix_addr;
  logic                pix_data = 1'b0;
  logic                R1out;
  logic [ROW_BITS-1:0] Aout;
  logic                sclk_out;
  logic                latout;
  logic                oe_nout;
  logic                frame_done;

  led_row_scanner #(
    .COLS     (COLS),
    .ROW_BITS (ROW_BITS),
    .CLK_DIV  (CLK_DIV),
    .SHOW_CYC (SHOW_CYC)
  ) dut (
    .clkin      (clkin),
    .rstnin     (rstnin),
    .enin       (enin),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .R1out      (R1out),
    .Aout       (Aout),
    .sclk_out   (sclk_out),
    .latout     (latout),
    .oe_nout    (oe_nout),
    .frame_done (frame_done)
  );

  always #5 clkin = ~clkin;

  logic mem [2**AW];
  always @(posedge clkin) pix_data <= mem[pix_addr];

  typedef struct {
    logic [0:3] bits;
    logic       en;
    logic       exp_a;
    logic       exp_fd;
    int         exp_lat;
  } row_vec_t;

  row_vec_t vecs [4];

  int   checks   = 0;
  int   errors   = 0;
  int   fd_count = 0;
  logic prev_a   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clkin);
    if (rstnin) begin
      chk("sclk_lat_overlap", {31'd0, sclk_out & latout}, 32'd0);
      if (Aout !== prev_a && !latout) chk("aout_outside_latch", {31'd0, Aout}, {31'd0, prev_a});
    end
    prev_a = Aout;
    if (frame_done) fd_count++;
  endtask

  task automatic scan_row(input row_vec_t v, input int idx);
    int   rises  = 0;
    int   steps  = 0;
    int   first  = 0;
    int   lat_w  = 0;
    int   oe_low = 0;
    logic prev_sclk = 1'b0;
    enin = v.en;
    while (rises < COLS && steps < 200) begin
      tick();
      steps++;
      if (sclk_out && !prev_sclk) begin
        if (rises == 0) first = steps;
        chk($sformatf("row%0d_bit%0d", idx, rises), {31'd0, R1out}, {31'd0, v.bits[rises]});
        chk($sformatf("row%0d_addr%0d", idx, rises), {{(32-AW){1'b0}}, pix_addr},
            v.exp_a * COLS + rises);
        chk("oe_during_shift", {31'd0, oe_nout}, {31'd0, OE_SCAN});
        rises++;
      end
      prev_sclk = sclk_out;
    end
    chk("sclk_rises", rises, COLS);
    chk("first_rise_latency", first, v.exp_lat);
    steps = 0;
    while (!latout && steps < 20) begin
      tick();
      steps++;
    end
    chk("aout_at_latch", {31'd0, Aout}, {31'd0, v.exp_a});
    while (latout && steps < 40) begin
      chk("oe_during_latch", {31'd0, oe_nout}, {31'd0, OE_SCAN});
      lat_w++;
      tick();
      steps++;
    end
    chk("latch_width", lat_w, CLK_DIV);
    for (int i = 0; i < SHOW_CYC; i++) begin
      if (oe_nout == 1'b0) oe_low++;
      tick();
    end
    chk("show_oe_low_cycles", oe_low, SHOW_CYC);
    chk("frame_done", {31'd0, frame_done}, {31'd0, v.exp_fd});
    $display("row %0d: bits=%b A=%0d latch=%0d oe_low=%0d frame_done=%0d",
             idx, v.bits, Aout, lat_w, oe_low, frame_done);
  endtask

  initial begin
    int rises;
    int steps;
    logic prev_sclk;

    vecs[0] = '{bits: 4'b1010, en: 1'b1, exp_a: 1'b0, exp_fd: 1'b0, exp_lat: 3};
    vecs[1] = '{bits: 4'b0110, en: 1'b1, exp_a: 1'b1, exp_fd: 1'b1, exp_lat: 2};
    vecs[2] = '{bits: 4'b1010, en: 1'b0, exp_a: 1'b0, exp_fd: 1'b0, exp_lat: 2};
    vecs[3] = '{bits: 4'b0110, en: 1'b0, exp_a: 1'b1, exp_fd: 1'b1, exp_lat: 2};
    for (int c = 0; c < COLS; c++) begin
      mem[c]        = vecs[0].bits[c];
      mem[COLS + c] = vecs[1].bits[c];
    end

    rstnin = 1'b0;
    enin   = 1'b1;
    repeat (3) tick();
    chk("rst_r1",       {31'd0, R1out},      32'd0);
    chk("rst_aout",     {31'd0, Aout},       32'd0);
    chk("rst_sclk",     {31'd0, sclk_out},   32'd0);
    chk("rst_lat",      {31'd0, latout},     32'd0);
    chk("rst_oe_n",     {31'd0, oe_nout},    32'd1);
    chk("rst_fd",       {31'd0, frame_done}, 32'd0);
    chk("rst_pix_addr", {{(32-AW){1'b0}}, pix_addr}, 32'd0);
    rstnin = 1'b1;

    // Two frames back to back; enin drops at the start of the second, which still completes.
    for (int i = 0; i < 4; i++) scan_row(vecs[i], i);

    rises = 0;
    prev_sclk = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sclk_out && !prev_sclk) rises++;
      prev_sclk = sclk_out;
    end
    chk("idle_no_shift", rises, 0);
    chk("idle_oe_n",     {31'd0, oe_nout}, 32'd1);
    chk("idle_lat",      {31'd0, latout},  32'd0);
    chk("idle_aout",     {31'd0, Aout},    32'd1);
    chk("frames_done",   fd_count,         2);

    // Restart, then hit reset during column 2 of row 0.
    enin = 1'b1;
    rises = 0;
    steps = 0;
    prev_sclk = 1'b0;
    while (rises < 2 && steps < 100) begin
      tick();
      steps++;
      if (sclk_out && !prev_sclk) rises++;
      prev_sclk = sclk_out;
    end
    chk("restart_rises", rises, 2);
    tick();
    tick();
    chk("col2_addr", {{(32-AW){1'b0}}, pix_addr}, 32'd2);
    #1 rstnin = 1'b0;
    #1;
    chk("arst_pix_addr", {{(32-AW){1'b0}}, pix_addr}, 32'd0);
    chk("arst_aout",     {31'd0, Aout},       32'd0);
    chk("arst_sclk",     {31'd0, sclk_out},   32'd0);
    chk("arst_lat",      {31'd0, latout},     32'd0);
    chk("arst_oe_n",     {31'd0, oe_nout},    32'd1);
    chk("arst_r1",       {31'd0, R1out},      32'd0);
    chk("arst_fd",       {31'd0, frame_done}, 32'd0);
    tick();
    rstnin = 1'b1;
    scan_row(vecs[0], 4);
    scan_row(vecs[3], 5);
    chk("frames_done_total", fd_count, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
